// File: rtl/team_06_sram_arb_pkg.sv
// Shared types and widths for the two-requester SRAM arbiter.
package team_06_sram_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int SEL_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

endpackage

// File: rtl/team_06_sram_arbiter_if.sv
// Requester and Wishbone-manager signal bundle for the SRAM arbiter.
interface team_06_sram_arbiter_if;
   import team_06_sram_arb_pkg::*;

   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_write;
   logic [ADDR_W-1:0]  req_addr0;
   logic [ADDR_W-1:0]  req_addr1;
   logic [DATA_W-1:0]  req_wdata0;
   logic [DATA_W-1:0]  req_wdata1;
   logic [SEL_W-1:0]   req_sel0;
   logic [SEL_W-1:0]   req_sel1;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] req_done;
   logic [NUM_REQ-1:0] req_err;
   logic [DATA_W-1:0]  req_rdata;
   logic [ADDR_W-1:0]  mgr_addr;
   logic [DATA_W-1:0]  mgr_wdata;
   logic [SEL_W-1:0]   mgr_sel;
   logic               mgr_write;
   logic               mgr_read;
   logic [DATA_W-1:0]  mgr_rdata;
   logic               mgr_busy;

   modport slave (
      input  req_valid, req_write, req_addr0, req_addr1,
      input  req_wdata0, req_wdata1, req_sel0, req_sel1,
      input  mgr_rdata, mgr_busy,
      output grant, req_done, req_err, req_rdata,
      output mgr_addr, mgr_wdata, mgr_sel, mgr_write, mgr_read
   );

   modport master (
      output req_valid, req_write, req_addr0, req_addr1,
      output req_wdata0, req_wdata1, req_sel0, req_sel1,
      output mgr_rdata, mgr_busy,
      input  grant, req_done, req_err, req_rdata,
      input  mgr_addr, mgr_wdata, mgr_sel, mgr_write, mgr_read
   );

endinterface

// File: rtl/team_06_rr_select.sv
// Combinational round-robin pick between the two requesters.
module team_06_rr_select
   import team_06_sram_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               last,
   output logic [NUM_REQ-1:0] winner
);

   // On a tie the requester that was not served last wins.
   always_comb begin
      winner = '0;
      if (&req_valid)
         winner = last ? 2'b01 : 2'b10;
      else if (req_valid[0])
         winner = 2'b01;
      else if (req_valid[1])
         winner = 2'b10;
   end

endmodule

// File: rtl/team_06_sram_arbiter.sv
// Two-requester round-robin arbiter in front of a Wishbone manager.
// Optional stall timeout enabled by defining TEAM_06_SRAM_ARB_TIMEOUT_EN.
module team_06_sram_arbiter
   import team_06_sram_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                   hwclk,
   input logic                   reset,
   team_06_sram_arbiter_if.slave bus
);

   state_t             state;
   state_t             state_nxt;
   logic [NUM_REQ-1:0] winner;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] req_done;
   logic               last;
   logic               op_write;
   logic               winner_write;
   logic               tmo;
   logic               enter_resp;
   logic               take_req;
   logic [DATA_W-1:0]  req_rdata;
   logic [DATA_W-1:0]  mgr_wdata;
   logic [ADDR_W-1:0]  mgr_addr;
   logic [SEL_W-1:0]   mgr_sel;
   logic               mgr_write;
   logic               mgr_read;

   generate
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   team_06_rr_select u_rr (
      .req_valid (bus.req_valid),
      .last      (last),
      .winner    (winner)
   );

   assign winner_write = |(winner & bus.req_write);
   assign take_req     = (state == IDLE) && (|bus.req_valid);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (|bus.req_valid) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tmo)
               state_nxt = RESP;
            else if (bus.mgr_busy)
               state_nxt = WAIT_DONE;
         end
         WAIT_DONE: if (tmo || !bus.mgr_busy) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign enter_resp = (state_nxt == RESP) && (state != RESP);

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         grant     <= '0;
         last      <= 1'b1;
         op_write  <= 1'b0;
         mgr_write <= 1'b0;
         mgr_read  <= 1'b0;
         mgr_addr  <= '0;
         mgr_wdata <= '0;
         mgr_sel   <= '0;
         req_done  <= '0;
         req_rdata <= '0;
      end else begin
         mgr_write <= 1'b0;
         mgr_read  <= 1'b0;
         req_done  <= '0;
         // Latch the winner's fields; they stay frozen until the next grant.
         if (take_req) begin
            grant     <= winner;
            op_write  <= winner_write;
            mgr_write <= winner_write;
            mgr_read  <= !winner_write;
            mgr_addr  <= winner[1] ? bus.req_addr1  : bus.req_addr0;
            mgr_wdata <= winner[1] ? bus.req_wdata1 : bus.req_wdata0;
            mgr_sel   <= winner[1] ? bus.req_sel1   : bus.req_sel0;
         end
         if (enter_resp) begin
            req_done  <= grant;
            req_rdata <= (tmo || op_write) ? '0 : bus.mgr_rdata;
         end
         if (state == RESP) begin
            grant <= '0;
            last  <= grant[1];
         end
      end
   end

`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
   logic [31:0]        tmo_cnt;
   logic [NUM_REQ-1:0] req_err;

   assign tmo = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent waiting on the manager; restarts for every grant.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset)
         tmo_cnt <= '0;
      else if (take_req)
         tmo_cnt <= '0;
      else if ((state == WAIT_BUSY) || (state == WAIT_DONE))
         tmo_cnt <= tmo_cnt + 32'd1;
   end

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset)
         req_err <= '0;
      else
         req_err <= tmo ? grant : '0;
   end

   assign bus.req_err = req_err;
`else
   assign tmo         = 1'b0;
   assign bus.req_err = '0;
`endif

   assign bus.grant     = grant;
   assign bus.req_done  = req_done;
   assign bus.req_rdata = req_rdata;
   assign bus.mgr_addr  = mgr_addr;
   assign bus.mgr_wdata = mgr_wdata;
   assign bus.mgr_sel   = mgr_sel;
   assign bus.mgr_write = mgr_write;
   assign bus.mgr_read  = mgr_read;

endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Scoreboard bench for team_06_sram_arbiter with a simple busy-flag manager model.
module tb_team_06_sram_arbiter;
   import team_06_sram_arb_pkg::*;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } strb_t;

   typedef struct {
      logic [1:0]  done;
      logic [1:0]  err;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   logic hwclk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   c0;
   int   hold;
   logic hang;
   logic abort;
   logic [31:0] next_rdata;
   logic [1:0]  m;
   strb_t strb_q[$];
   resp_t resp_q[$];

   always #5 hwclk = ~hwclk;
   always @(posedge hwclk) cyc <= cyc + 1;

   team_06_sram_arbiter_if bus();

   team_06_sram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .hwclk (hwclk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge hwclk);
      #1;
   endtask

   task automatic wait_done(output logic [1:0] mask);
      mask = '0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (bus.req_done != 2'b00) begin
            mask = bus.req_done;
            return;
         end
      end
      n_chk++;
      $display("FAIL done_wait: no req_done within 64 cycles (cycle %0d)", cyc);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"},     32'(bus.grant), 32'h0);
      check({tag, "_req_done"},  32'(bus.req_done), 32'h0);
      check({tag, "_req_err"},   32'(bus.req_err), 32'h0);
      check({tag, "_req_rdata"}, bus.req_rdata, 32'h0);
      check({tag, "_mgr_write"}, 32'(bus.mgr_write), 32'h0);
      check({tag, "_mgr_read"},  32'(bus.mgr_read), 32'h0);
      check({tag, "_mgr_addr"},  bus.mgr_addr, 32'h0);
      check({tag, "_mgr_wdata"}, bus.mgr_wdata, 32'h0);
      check({tag, "_mgr_sel"},   32'(bus.mgr_sel), 32'h0);
   endtask

   // Manager model: busy rises two cycles after a strobe, falls after hold cycles.
   initial begin : responder
      int wait_cnt;
      int hold_cnt;
      wait_cnt = 0;
      hold_cnt = 0;
      bus.mgr_busy  = 1'b0;
      bus.mgr_rdata = 32'h0;
      forever begin
         tick();
         if (abort) begin
            bus.mgr_busy = 1'b0;
            wait_cnt = 0;
            hold_cnt = 0;
         end else if (bus.mgr_write || bus.mgr_read) begin
            wait_cnt = 2;
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               bus.mgr_busy  = 1'b1;
               bus.mgr_rdata = 32'hBAD0BAD0;
               hold_cnt = hold;
            end
         end else if (bus.mgr_busy && !hang) begin
            hold_cnt--;
            if (hold_cnt <= 0) begin
               bus.mgr_busy  = 1'b0;
               bus.mgr_rdata = next_rdata;
            end
         end
      end
   end

   initial begin : monitor
      logic        gap;
      logic [31:0] cur_addr;
      strb_t       s;
      resp_t       r;
      gap = 1'b0;
      cur_addr = 32'h0;
      forever begin
         @(negedge hwclk);
         if (bus.mgr_write || bus.mgr_read) begin
            if (strb_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_strobe: write=%0b read=%0b addr=0x%08h (cycle %0d)",
                        bus.mgr_write, bus.mgr_read, bus.mgr_addr, cyc);
            end else begin
               s = strb_q.pop_front();
               check("strobe_write", 32'(bus.mgr_write), 32'(s.w));
               check("strobe_read",  32'(bus.mgr_read), 32'(!s.w));
               check("strobe_addr",  bus.mgr_addr, s.addr);
               check("strobe_wdata", bus.mgr_wdata, s.wdata);
               check("strobe_sel",   32'(bus.mgr_sel), 32'(s.sel));
               cur_addr = s.addr;
            end
         end
         if (bus.mgr_busy && (bus.grant != 2'b00))
            check("addr_stable", bus.mgr_addr, cur_addr);
         if (bus.req_done != 2'b00) begin
            if (resp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_done: req_done=%02b (cycle %0d)", bus.req_done, cyc);
            end else begin
               r = resp_q.pop_front();
               check("done_mask",  32'(bus.req_done), 32'(r.done));
               check("done_err",   32'(bus.req_err), 32'(r.err));
               check("done_rdata", bus.req_rdata, r.rdata);
               check("done_grant", 32'(bus.grant), 32'(r.done));
               if (r.cyc >= 0)
                  check("done_cycle", 32'(cyc), 32'(r.cyc));
            end
            gap = 1'b1;
         end else if (gap) begin
            check("idle_gap_grant", 32'(bus.grant), 32'h0);
            gap = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1;
      hang = 1'b0;
      abort = 1'b0;
      hold = 2;
      next_rdata = 32'h0;
      bus.req_valid  = 2'b00;
      bus.req_write  = 2'b00;
      bus.req_addr0  = 32'h0;
      bus.req_addr1  = 32'h0;
      bus.req_wdata0 = 32'h0;
      bus.req_wdata1 = 32'h0;
      bus.req_sel0   = 4'h0;
      bus.req_sel1   = 4'h0;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Single write from requester 0, busy high in cycles 3-4.
      tick();
      c0 = cyc;
      hold = 2;
      next_rdata = 32'hFFFF0000;
      bus.req_valid  = 2'b01;
      bus.req_write  = 2'b01;
      bus.req_addr0  = 32'h10;
      bus.req_wdata0 = 32'hDEADBEEF;
      bus.req_sel0   = 4'hF;
      strb_q.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
      resp_q.push_back('{2'b01, 2'b00, 32'h0, c0 + 6});
      wait_done(m);
      bus.req_valid = 2'b00;

      // Read from requester 1 at minimum latency.
      tick();
      c0 = cyc;
      hold = 1;
      next_rdata = 32'h12345678;
      bus.req_valid  = 2'b10;
      bus.req_write  = 2'b00;
      bus.req_addr1  = 32'h20;
      bus.req_wdata1 = 32'h55;
      bus.req_sel1   = 4'h3;
      strb_q.push_back('{1'b0, 32'h20, 32'h55, 4'h3});
      resp_q.push_back('{2'b10, 2'b00, 32'h12345678, c0 + 5});
      wait_done(m);
      bus.req_valid = 2'b00;

      // Both requesters held: grants must alternate 01,10,01,10.
      tick();
      hold = 2;
      next_rdata = 32'hCAFEF00D;
      bus.req_write  = 2'b01;
      bus.req_addr0  = 32'hA0;
      bus.req_wdata0 = 32'h11111111;
      bus.req_sel0   = 4'h5;
      bus.req_addr1  = 32'hB0;
      bus.req_wdata1 = 32'h22222222;
      bus.req_sel1   = 4'hA;
      for (int i = 0; i < 2; i++) begin
         strb_q.push_back('{1'b1, 32'hA0, 32'h11111111, 4'h5});
         resp_q.push_back('{2'b01, 2'b00, 32'h0, -1});
         strb_q.push_back('{1'b0, 32'hB0, 32'h22222222, 4'hA});
         resp_q.push_back('{2'b10, 2'b00, 32'hCAFEF00D, -1});
      end
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++)
         wait_done(m);
      bus.req_valid = 2'b00;

      // Owner drops req_valid mid-transaction; completion still reported.
      tick();
      c0 = cyc;
      next_rdata = 32'h600DCAFE;
      bus.req_valid  = 2'b01;
      bus.req_write  = 2'b00;
      bus.req_addr0  = 32'h44;
      bus.req_wdata0 = 32'h0;
      bus.req_sel0   = 4'hC;
      strb_q.push_back('{1'b0, 32'h44, 32'h0, 4'hC});
      resp_q.push_back('{2'b01, 2'b00, 32'h600DCAFE, c0 + 6});
      repeat (2) tick();
      bus.req_valid = 2'b00;
      wait_done(m);

`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
      // Manager never drops busy: timeout 8 cycles after WAIT_BUSY entry.
      tick();
      c0 = cyc;
      hang = 1'b1;
      next_rdata = 32'h77777777;
      bus.req_valid  = 2'b01;
      bus.req_write  = 2'b00;
      bus.req_addr0  = 32'h50;
      bus.req_wdata0 = 32'hA5A5A5A5;
      bus.req_sel0   = 4'hF;
      strb_q.push_back('{1'b0, 32'h50, 32'hA5A5A5A5, 4'hF});
      resp_q.push_back('{2'b01, 2'b01, 32'h0, c0 + 10});
      wait_done(m);
      bus.req_valid = 2'b00;
      abort = 1'b1;
      repeat (2) tick();
      abort = 1'b0;
      hang = 1'b0;
      tick();
`endif

      // Reset while waiting on the manager drops the transaction silently.
      tick();
      hang = 1'b1;
      hold = 2;
      bus.req_valid  = 2'b01;
      bus.req_write  = 2'b01;
      bus.req_addr0  = 32'h80;
      bus.req_wdata0 = 32'h77;
      bus.req_sel0   = 4'h3;
      strb_q.push_back('{1'b1, 32'h80, 32'h77, 4'h3});
      repeat (4) tick();
      check("midop_busy_seen", 32'(bus.mgr_busy), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midop_reset");
      bus.req_valid = 2'b00;
      abort = 1'b1;
      repeat (2) tick();
      abort = 1'b0;
      hang = 1'b0;
      reset = 1'b0;
      tick();

      // First tie after reset goes to requester 0.
      next_rdata = 32'h13579BDF;
      bus.req_write  = 2'b11;
      bus.req_addr0  = 32'hC0;
      bus.req_wdata0 = 32'h1234;
      bus.req_sel0   = 4'h1;
      bus.req_addr1  = 32'hD0;
      bus.req_wdata1 = 32'h5678;
      bus.req_sel1   = 4'h8;
      strb_q.push_back('{1'b1, 32'hC0, 32'h1234, 4'h1});
      resp_q.push_back('{2'b01, 2'b00, 32'h0, -1});
      strb_q.push_back('{1'b1, 32'hD0, 32'h5678, 4'h8});
      resp_q.push_back('{2'b10, 2'b00, 32'h0, -1});
      bus.req_valid = 2'b11;
      wait_done(m);
      bus.req_valid[0] = 1'b0;
      wait_done(m);
      bus.req_valid = 2'b00;

      repeat (5) tick();
      check("strobe_queue_drained", 32'(strb_q.size()), 32'h0);
      check("resp_queue_drained",   32'(resp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/team_06_sram_arbiter.md
TEAM_06_SRAM_ARBITER -- requirements
Module: team_06_sram_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, number of cycles after which a stalled manager transaction is abandoned.
REQ-002 Port: hwclk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: req_valid  input  2  per-requester request; bit 0 is the echo/record path, bit 1 is the playback path.
REQ-005 Port: req_write  input  2  per-requester operation: 1 = write, 0 = read.
REQ-006 Port: req_addr0, req_addr1  input  32 each  word address per requester.
REQ-007 Port: req_wdata0, req_wdata1  input  32 each  write data per requester.
REQ-008 Port: req_sel0, req_sel1  input  4 each  byte select per requester.
REQ-009 Port: grant  output  2  one-hot owner of the current transaction; 0 when idle.
REQ-010 Port: req_done  output  2  one-cycle completion pulse to the owning requester.
REQ-011 Port: req_err  output  2  one-cycle timeout pulse; coincides with req_done.
REQ-012 Port: req_rdata  output  32  read data; valid while req_done is high.
REQ-013 Port: mgr_addr, mgr_wdata  output  32 each  address and write data to the Wishbone manager.
REQ-014 Port: mgr_sel  output  4  byte select to the manager.
REQ-015 Port: mgr_write, mgr_read  output  1 each  one-cycle strobes to the manager.
REQ-016 Port: mgr_rdata  input  32  read data from the manager.
REQ-017 Port: mgr_busy  input  1  manager busy flag.

Function
REQ-018 States SHALL be: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-019 IDLE SHALL take any req_valid bit set and, on the next edge, register grant and the winner's addr/wdata/sel/write, then enter ISSUE.
REQ-020 Arbitration SHALL be round-robin: if both bits are set, the requester not granted last wins; otherwise the sole requester wins.
REQ-021 ISSUE SHALL hold mgr_write (write op) or mgr_read (read op) high for exactly one cycle, then enter WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL go to WAIT_DONE on mgr_busy=1.
REQ-023 WAIT_DONE SHALL, on mgr_busy=0, capture mgr_rdata into req_rdata and enter RESP.
REQ-024 RESP SHALL pulse req_done[owner] for one cycle, update the last-grant record, clear grant, and return to IDLE.
REQ-025 A new grant SHALL NOT be made in RESP, so there is at least one IDLE cycle between transactions.
REQ-026 mgr_addr, mgr_wdata and mgr_sel SHALL stay stable from ISSUE through WAIT_DONE.
REQ-027 For writes, req_rdata SHALL be 0.
REQ-028 If the owner drops req_valid mid-transaction, the transaction SHALL still complete and req_done SHALL still pulse.
REQ-029 Requesters SHALL hold their fields stable while req_valid is high and no req_done has been received.
REQ-030 The losing requester SHALL stay pending and be served next; starvation bound is one transaction.
REQ-031 Minimum latency, with req_valid at cycle 0 and mgr_busy high in cycle 3 and low in cycle 4, SHALL be req_done at cycle 5.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, with grant, req_done, req_err, req_rdata, mgr_* outputs and the timeout counter all 0.
REQ-033 Reset SHALL set the last-grant record to 1, so requester 0 wins the first tie.
REQ-034 A transaction in flight when reset asserts SHALL be dropped with no req_done; the requester re-presents it.

Configuration
REQ-035 With macro TEAM_06_SRAM_ARB_TIMEOUT_EN defined, a counter SHALL run during WAIT_BUSY and WAIT_DONE.
REQ-036 With the macro defined, reaching TIMEOUT_CYCLES SHALL force RESP with req_err[owner]=1, req_done[owner]=1 and req_rdata=0.
REQ-037 With the macro defined, the counter SHALL clear on entry to ISSUE.
REQ-038 Without the macro, the arbiter SHALL wait indefinitely and req_err SHALL be tied to 0.

Structure
REQ-039 Package team_06_sram_arb_pkg SHALL hold the state enum, NUM_REQ=2, ADDR_W=32, DATA_W=32 and SEL_W=4.
REQ-040 Sub-module team_06_rr_select SHALL be the combinational round-robin pick (inputs req_valid and last; output one-hot winner); everything else is in the top FSM.

Verification
REQ-041 Write: req_valid=01, write, addr0=0x10, wdata0=0xDEADBEEF, sel0=0xF, busy high cycles 3-4 -> mgr_write pulses once with those values; req_done=01 at cycle 6; rdata=0.
REQ-042 Read: req_valid=10, read, addr1=0x20, mgr_rdata=0x12345678 when busy falls -> mgr_read pulses once; req_done=10; req_rdata=0x12345678.
REQ-043 Contention: req_valid=11 held through four transactions after reset -> grant order 01,10,01,10, with one IDLE cycle between each.
REQ-044 Timeout (macro on, TIMEOUT_CYCLES=8): mgr_busy held 1 -> req_done and req_err pulse for the owner exactly 8 cycles after WAIT_BUSY entry; req_rdata=0.
REQ-045 Reset mid-op: reset asserted in WAIT_DONE -> all outputs 0 immediately; no req_done; after release, req_valid=11 is granted to 01 first.
